pending_encoder8to3: RTL and testbench

Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoders. It accumulates request bits from an 8-bit vector into a pending register and presents each pending bit, one at a time, as a 3-bit index on a valid/ready output handshake. Each bit is cleared when its index is accepted. It sits downstream of event or flag sources and feeds consumers that expect a binary code, such as a decoder on the far side of a narrow bus.

---
 rtl/pending_encoder8to3.sv | 126 ++++++++++++
 tb/tb_pending_encoder8to3.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pending_encoder8to3.sv
// Sequential 8-to-3 encoder: accumulates request bits and offers them one index at a time on a valid/ready handshake.
// Define PENC_ROUND_ROBIN_EN for rotating priority; otherwise the lowest pending index wins.
module pending_encoder8to3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] d,
  input  logic       d_valid,
  output logic [2:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic [7:0] pending,
  output logic       overflow
);

  // state | meaning
  // IDLE  | nothing offered, y = 0
  // OFFER | y holds a pending index until accepted
  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [2:0] y_d;
  logic [7:0] pending_d;
  logic       overflow_d;
  logic       accept;
  logic [7:0] offered_mask, accept_mask, remaining, req;
  logic [2:0] idle_start, next_start;

  // Search starts at 'start' and wraps 7 -> 0; the first set bit found wins.
  function automatic logic [2:0] select_idx(input logic [7:0] v, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] sel;
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (v[idx]) sel = idx;
    end
    return sel;
  endfunction

`ifdef PENC_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  assign idle_start = ptr_q;
  assign next_start = y + 3'd1;
`else
  assign idle_start = 3'd0;
  assign next_start = 3'd0;
`endif

  assign y_valid = (state_q == OFFER);

  always_comb begin
    accept       = y_valid & y_ready;
    offered_mask = 8'b1 << y;
    accept_mask  = accept ? offered_mask : 8'h00;
    remaining    = pending & ~offered_mask;
    req          = d_valid ? d : 8'h00;

    state_d    = state_q;
    y_d        = y;
    pending_d  = (pending & ~accept_mask) | req;
    overflow_d = overflow | (|(req & pending & ~accept_mask));
`ifdef PENC_ROUND_ROBIN_EN
    ptr_d = ptr_q;
`endif

    if (clr) begin
      state_d    = IDLE;
      y_d        = 3'd0;
      pending_d  = 8'h00;
      overflow_d = 1'b0;
`ifdef PENC_ROUND_ROBIN_EN
      ptr_d = 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          y_d = 3'd0;
          if (|pending) begin
            y_d     = select_idx(pending, idle_start);
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
`ifdef PENC_ROUND_ROBIN_EN
            ptr_d = y + 3'd1;
`endif
            // Re-select from the bits already pending; same-cycle re-requests wait for the next pass.
            if (|remaining) begin
              y_d = select_idx(remaining, next_start);
            end else begin
              y_d     = 3'd0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          y_d     = 3'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y        <= 3'd0;
      pending  <= 8'h00;
      overflow <= 1'b0;
`ifdef PENC_ROUND_ROBIN_EN
      ptr_q    <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      y        <= y_d;
      pending  <= pending_d;
      overflow <= overflow_d;
`ifdef PENC_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pending_encoder8to3.sv
// Self-checking bench for pending_encoder8to3: directed scenarios plus randomized traffic
// against a transaction-level model of the pending set and offer sequence.
module tb_pending_encoder8to3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready = 1'b0;
  logic [7:0] pending;
  logic       overflow;

  int total = 0;
  int bad = 0;

  int m_pend, m_y, m_ptr;
  bit m_valid, m_ovf;

  pending_encoder8to3 dut (
    .clk(clk), .rst(rst), .clr(clr), .d(d), .d_valid(d_valid),
    .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int pick(int v, int start);
    for (int off = 0; off < 8; off++) begin
      int k;
      k = (start + off) % 8;
      if (((v >> k) & 1) != 0) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_y = 0; m_ptr = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit past it.
  task automatic tick(input logic [7:0] dv_d, input logic dv, input logic rdy, input logic c);
    int old_p, old_y, mask, rem, start;
    bit old_v, acc;
    d = dv_d; d_valid = dv; y_ready = rdy; clr = c;
    @(posedge clk);
    old_p = m_pend; old_y = m_y; old_v = m_valid;
    acc  = old_v && rdy;
    mask = acc ? (1 << old_y) : 0;
    if (c) begin
      model_reset();
    end else begin
      if (dv && ((int'(dv_d) & old_p & ~mask) != 0)) m_ovf = 1;
      m_pend = ((old_p & ~mask) | (dv ? int'(dv_d) : 0)) & 255;
      if (!old_v) begin
        if (old_p != 0) begin
`ifdef PENC_ROUND_ROBIN_EN
          start = m_ptr;
`else
          start = 0;
`endif
          m_y = pick(old_p, start);
          m_valid = 1;
        end
      end else if (acc) begin
        m_ptr = (old_y + 1) % 8;
        rem = old_p & ~mask;
        if (rem != 0) begin
`ifdef PENC_ROUND_ROBIN_EN
          start = m_ptr;
`else
          start = 0;
`endif
          m_y = pick(rem, start);
        end else begin
          m_valid = 0;
          m_y = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #3; rst = 1'b0;
    model_reset();
    tick(8'h20, 1, 0, 0);
    tick(8'h00, 0, 0, 0);
    tick(8'h01, 1, 0, 0);
    total++;
    if (y !== 3'd5 || y_valid !== 1'b1 || pending !== 8'h21) begin
      bad++; $display("FAIL reset_setup: y=%0d v=%b pend=%h, want y=5 v=1 pend=21", y, y_valid, pending);
    end
    #2 rst = 1'b1; #1;
    total++;
    if (y !== 3'd0 || y_valid !== 1'b0 || pending !== 8'h00 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_async: y=%0d v=%b pend=%h ovf=%b, want all 0", y, y_valid, pending, overflow);
    end
    #3 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 0, 1, 0);
      total++;
      if (y_valid !== 1'b0) begin
        bad++; $display("FAIL reset_quiet: y_valid=%b, want 0", y_valid);
      end
    end
  endtask

  task automatic test_single();
    tick(8'h20, 1, 0, 0);
    total++;
    if (pending !== 8'h20 || y_valid !== 1'b0) begin
      bad++; $display("FAIL single_c1: pend=%h v=%b, want 20 0", pending, y_valid);
    end
    tick(8'h00, 0, 0, 0);
    total++;
    if (y_valid !== 1'b1 || y !== 3'd5) begin
      bad++; $display("FAIL single_offer: v=%b y=%0d, want 1 5", y_valid, y);
    end
    tick(8'h00, 0, 1, 0);
    total++;
    if (pending !== 8'h00 || y_valid !== 1'b0) begin
      bad++; $display("FAIL single_accept: pend=%h v=%b, want 00 0", pending, y_valid);
    end
  endtask

  task automatic test_burst();
    int exp_seq[3];
    tick(8'h00, 0, 0, 1);
    tick(8'h92, 1, 1, 0);
`ifdef PENC_ROUND_ROBIN_EN
    exp_seq = '{1, 4, 7};
`else
    exp_seq = '{1, 4, 7};
`endif
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 0, 1, 0);
      total++;
      if (y_valid !== 1'b1 || int'(y) != exp_seq[i]) begin
        bad++; $display("FAIL burst_%0d: v=%b y=%0d, want 1 %0d", i, y_valid, y, exp_seq[i]);
      end
    end
    tick(8'h00, 0, 1, 0);
    total++;
    if (y_valid !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL burst_idle: v=%b pend=%h, want 0 00", y_valid, pending);
    end
  endtask

  task automatic test_rr_order();
    int first, second;
`ifdef PENC_ROUND_ROBIN_EN
    first = 6; second = 1;
`else
    first = 1; second = 6;
`endif
    tick(8'h00, 0, 0, 1);
    tick(8'h10, 1, 0, 0);
    tick(8'h00, 0, 0, 0);
    total++;
    if (y !== 3'd4) begin
      bad++; $display("FAIL rr_first4: y=%0d, want 4", y);
    end
    tick(8'h00, 0, 1, 0);
    tick(8'h42, 1, 0, 0);
    tick(8'h00, 0, 0, 0);
    total++;
    if (y_valid !== 1'b1 || int'(y) != first) begin
      bad++; $display("FAIL rr_order_a: v=%b y=%0d, want 1 %0d", y_valid, y, first);
    end
    tick(8'h00, 0, 1, 0);
    total++;
    if (y_valid !== 1'b1 || int'(y) != second) begin
      bad++; $display("FAIL rr_order_b: v=%b y=%0d, want 1 %0d", y_valid, y, second);
    end
    tick(8'h00, 0, 1, 0);
  endtask

  task automatic test_stall_overflow();
    tick(8'h00, 0, 0, 1);
    tick(8'h04, 1, 0, 0);
    tick(8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(8'h00, 0, 0, 0);
      total++;
      if (y !== 3'd2 || y_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold: y=%0d v=%b, want 2 1", y, y_valid);
      end
    end
    tick(8'h01, 1, 0, 0);
    total++;
    if (y !== 3'd2 || overflow !== 1'b0) begin
      bad++; $display("FAIL stall_nopreempt: y=%0d ovf=%b, want 2 0", y, overflow);
    end
    tick(8'h04, 1, 0, 0);
    total++;
    if (overflow !== 1'b1 || pending !== 8'h05) begin
      bad++; $display("FAIL overflow_set: ovf=%b pend=%h, want 1 05", overflow, pending);
    end
    tick(8'h00, 0, 1, 0);
    total++;
    if (y !== 3'd0 || y_valid !== 1'b1 || overflow !== 1'b1) begin
      bad++; $display("FAIL stall_next: y=%0d v=%b ovf=%b, want 0 1 1", y, y_valid, overflow);
    end
  endtask

  task automatic test_rerequest_clr();
    tick(8'h00, 0, 0, 1);
    tick(8'h08, 1, 0, 0);
    tick(8'h00, 0, 0, 0);
    tick(8'h08, 1, 1, 0);
    total++;
    if (pending !== 8'h08 || overflow !== 1'b0 || y_valid !== 1'b0) begin
      bad++; $display("FAIL rereq: pend=%h ovf=%b v=%b, want 08 0 0", pending, overflow, y_valid);
    end
    tick(8'h00, 0, 0, 0);
    total++;
    if (y_valid !== 1'b1 || y !== 3'd3) begin
      bad++; $display("FAIL rereq_reoffer: v=%b y=%0d, want 1 3", y_valid, y);
    end
    tick(8'hFF, 1, 1, 1);
    total++;
    if (pending !== 8'h00 || y_valid !== 1'b0 || overflow !== 1'b0 || y !== 3'd0) begin
      bad++; $display("FAIL clr_wins: pend=%h v=%b ovf=%b y=%0d, want 00 0 0 0", pending, y_valid, overflow, y);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd;
    tick(8'h00, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      rd = 8'($urandom);
      tick(rd, ($urandom % 3) == 0, ($urandom % 3) != 0, ($urandom % 80) == 0);
      total++;
      if (y_valid !== m_valid || y !== 3'(m_y) || pending !== 8'(m_pend) || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random_%0d: v=%b y=%0d pend=%h ovf=%b, want v=%b y=%0d pend=%h ovf=%b",
                 i, y_valid, y, pending, overflow, m_valid, m_y, m_pend[7:0], m_ovf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_rr_order();
    test_stall_overflow();
    test_rerequest_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
